sevenseg_readback_decoder: RTL and testbench

- Receive-side counterpart to the board's seven-segment drivers: samples the seven segment lines a..g and reconstructs the displayed hex digit.
- Used for on-board self-check and loopback test of counter/display logic on the same fabric clock.
- Synchronises the lines, filters glitches with a stability window and decodes the pattern.
- Reports new digits, blank and illegal patterns, and keeps a display-change counter.

---
 rtl/sevenseg_readback_decoder_if.sv | 22 ++
 rtl/sevenseg_readback_decoder.sv | 175 +++++++++++++++++
 tb/tb_sevenseg_readback_decoder.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/sevenseg_readback_decoder_if.sv
// Segment-line readback bus: raw a..g lines in, decoded digit/status out.
interface sevenseg_readback_decoder_if #(
  parameter int CNT_W = 16
);
  logic [6:0]       seg;
  logic [3:0]       digit;
  logic             blank;
  logic             invalid;
  logic             digit_valid;
  logic [CNT_W-1:0] change_cnt;
  logic             seq_err;

  modport master (
    output seg,
    input  digit, blank, invalid, digit_valid, change_cnt, seq_err
  );

  modport slave (
    input  seg,
    output digit, blank, invalid, digit_valid, change_cnt, seq_err
  );
endinterface

// File: rtl/sevenseg_readback_decoder.sv
// Seven-segment readback: sync, stability filter, decode, change counting.
// Optional SEVENSEG_SEQ_CHECK_EN adds a sticky decimal-sequence checker on seq_err.
//
// state      | meaning
// WAIT_FIRST | nothing accepted since reset
// SETTLING   | cand differs from acc, stability count running
// STABLE     | cand == acc
module sevenseg_readback_decoder #(
  parameter int ACTIVE_LOW    = 1,
  parameter int STABLE_CYCLES = 16,
  parameter int CNT_W         = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  sevenseg_readback_decoder_if.slave  bus
);

  typedef enum logic [1:0] {WAIT_FIRST, SETTLING, STABLE} state_t;

  localparam logic [15:0] STAB_MAX = 16'(STABLE_CYCLES - 1);

  logic [6:0]       s1_q, s2_q, n;
  logic [6:0]       cand_q, cand_d;
  logic [6:0]       acc_q, acc_d;
  logic [15:0]      stab_cnt_q, stab_cnt_d;
  state_t           state_q, state_d;
  logic [3:0]       digit_q, digit_d;
  logic             blank_q, blank_d;
  logic             invalid_q, invalid_d;
  logic             digit_valid_q, digit_valid_d;
  logic [CNT_W-1:0] change_cnt_q, change_cnt_d;
  logic             accept;
  logic [3:0]       dec_digit;
  logic             dec_blank, dec_invalid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q          <= '0;
      s2_q          <= '0;
      cand_q        <= '0;
      acc_q         <= '0;
      stab_cnt_q    <= '0;
      state_q       <= WAIT_FIRST;
      digit_q       <= '0;
      blank_q       <= 1'b0;
      invalid_q     <= 1'b0;
      digit_valid_q <= 1'b0;
      change_cnt_q  <= '0;
    end else begin
      s1_q          <= bus.seg;
      s2_q          <= s1_q;
      cand_q        <= cand_d;
      acc_q         <= acc_d;
      stab_cnt_q    <= stab_cnt_d;
      state_q       <= state_d;
      digit_q       <= digit_d;
      blank_q       <= blank_d;
      invalid_q     <= invalid_d;
      digit_valid_q <= digit_valid_d;
      change_cnt_q  <= change_cnt_d;
    end
  end

  assign n = (ACTIVE_LOW != 0) ? ~s2_q : s2_q;

  // Pattern bits are {a,b,c,d,e,f,g} with 1 = lit.
  always_comb begin
    dec_digit   = 4'd0;
    dec_blank   = 1'b0;
    dec_invalid = 1'b0;
    case (cand_q)
      7'h7E: dec_digit = 4'h0;
      7'h30: dec_digit = 4'h1;
      7'h6D: dec_digit = 4'h2;
      7'h79: dec_digit = 4'h3;
      7'h33: dec_digit = 4'h4;
      7'h5B: dec_digit = 4'h5;
      7'h5F: dec_digit = 4'h6;
      7'h70: dec_digit = 4'h7;
      7'h7F: dec_digit = 4'h8;
      7'h7B: dec_digit = 4'h9;
      7'h77: dec_digit = 4'hA;
      7'h1F: dec_digit = 4'hB;
      7'h4E: dec_digit = 4'hC;
      7'h3D: dec_digit = 4'hD;
      7'h4F: dec_digit = 4'hE;
      7'h47: dec_digit = 4'hF;
      7'h00: dec_blank = 1'b1;
      default: dec_invalid = 1'b1;
    endcase
  end

  assign accept = (n == cand_q) && (stab_cnt_q == STAB_MAX) &&
                  ((state_q == WAIT_FIRST) || (cand_q != acc_q));

  always_comb begin
    cand_d        = cand_q;
    acc_d         = acc_q;
    stab_cnt_d    = stab_cnt_q;
    state_d       = state_q;
    digit_d       = digit_q;
    blank_d       = blank_q;
    invalid_d     = invalid_q;
    digit_valid_d = 1'b0;
    change_cnt_d  = change_cnt_q;

    if (n != cand_q) begin
      cand_d     = n;
      stab_cnt_d = '0;
      if (state_q != WAIT_FIRST)
        state_d = (n == acc_q) ? STABLE : SETTLING;
    end else if (stab_cnt_q != STAB_MAX) begin
      stab_cnt_d = stab_cnt_q + 16'd1;
    end

    if (accept) begin
      acc_d         = cand_q;
      state_d       = STABLE;
      digit_valid_d = 1'b1;
      blank_d       = dec_blank;
      invalid_d     = dec_invalid;
      if (!dec_blank && !dec_invalid)
        digit_d = dec_digit;
      if (change_cnt_q != '1)
        change_cnt_d = change_cnt_q + 1'b1;
    end
  end

`ifdef SEVENSEG_SEQ_CHECK_EN
  logic [3:0] prev_q, prev_d;
  logic       prev_vld_q, prev_vld_d;
  logic       seq_err_q, seq_err_d;
  logic [4:0] prev_next;

  // Expected successor counts in decimal, so 9 wraps to 0.
  assign prev_next = 5'(({1'b0, prev_q} + 5'd1) % 5'd10);

  always_comb begin
    prev_d     = prev_q;
    prev_vld_d = prev_vld_q;
    seq_err_d  = seq_err_q;
    if (accept && !dec_blank && !dec_invalid) begin
      prev_d     = dec_digit;
      prev_vld_d = 1'b1;
      if (dec_digit > 4'd9)
        seq_err_d = 1'b1;
      else if (prev_vld_q && ({1'b0, dec_digit} != prev_next))
        seq_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      seq_err_q  <= 1'b0;
    end else begin
      prev_q     <= prev_d;
      prev_vld_q <= prev_vld_d;
      seq_err_q  <= seq_err_d;
    end
  end

  assign bus.seq_err = seq_err_q;
`else
  assign bus.seq_err = 1'b0;
`endif

  assign bus.digit       = digit_q;
  assign bus.blank       = blank_q;
  assign bus.invalid     = invalid_q;
  assign bus.digit_valid = digit_valid_q;
  assign bus.change_cnt  = change_cnt_q;

endmodule

// File: tb/tb_sevenseg_readback_decoder.sv
// Directed bench for sevenseg_readback_decoder (ACTIVE_LOW=1 lines).
module tb_sevenseg_readback_decoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  sevenseg_readback_decoder_if #(.CNT_W(16)) sif ();
  sevenseg_readback_decoder_if #(.CNT_W(2))  sif2 ();

  assign sif2.seg = sif.seg;

  sevenseg_readback_decoder #(.ACTIVE_LOW(1), .STABLE_CYCLES(16), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif.slave)
  );

  // Small second instance: shortest legal window and a 2-bit counter to hit saturation.
  sevenseg_readback_decoder #(.ACTIVE_LOW(1), .STABLE_CYCLES(2), .CNT_W(2)) dut_small (
    .clk (clk),
    .rst (rst),
    .bus (sif2.slave)
  );

  localparam int LAT = 19;

  function automatic logic [6:0] lit_code(input int d);
    case (d)
      0: return 7'h7E;  1: return 7'h30;  2: return 7'h6D;  3: return 7'h79;
      4: return 7'h33;  5: return 7'h5B;  6: return 7'h5F;  7: return 7'h70;
      8: return 7'h7F;  9: return 7'h7B;  10: return 7'h77; 11: return 7'h1F;
      12: return 7'h4E; 13: return 7'h3D; 14: return 7'h4F; default: return 7'h47;
    endcase
  endfunction

  task automatic hold(input logic [6:0] s, input int cycles, output int pulses, output int lat);
    sif.seg = s;
    pulses = 0;
    lat = -1;
    for (int i = 1; i <= cycles; i++) begin
      @(negedge clk);
      if (sif.digit_valid === 1'b1) begin
        pulses++;
        if (lat < 0) lat = i;
      end
    end
  endtask

  task automatic do_reset(input logic [6:0] s);
    @(negedge clk);
    sif.seg = s;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    int p, l;
    sif.seg = 7'h01;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({sif.digit, sif.blank, sif.invalid, sif.digit_valid, sif.change_cnt, sif.seq_err} !== 25'd0) begin
      errors++;
      $display("FAIL reset_outputs: got digit=%h blank=%b inv=%b dv=%b cnt=%0d seq=%b, need all 0",
               sif.digit, sif.blank, sif.invalid, sif.digit_valid, sif.change_cnt, sif.seq_err);
    end
    rst = 1'b0;
    hold(7'h01, 40, p, l);
    checks++;
    if (p !== 1 || l !== LAT) begin
      errors++; $display("FAIL first_accept: pulses=%0d lat=%0d, need 1 and %0d", p, l, LAT);
    end
    checks++;
    if ({sif.digit, sif.blank, sif.invalid} !== 6'b0000_00 || sif.change_cnt !== 16'd1) begin
      errors++;
      $display("FAIL first_outputs: digit=%h blank=%b inv=%b cnt=%0d, need 0 0 0 1",
               sif.digit, sif.blank, sif.invalid, sif.change_cnt);
    end
  endtask

  task automatic test_digits;
    int p, l;
    do_reset(~lit_code(0));
    for (int d = 0; d < 16; d++) begin
      hold(~lit_code(d), 40, p, l);
      checks++;
      if (p !== 1 || l !== LAT || sif.digit !== 4'(d) || sif.invalid !== 1'b0 || sif.blank !== 1'b0) begin
        errors++;
        $display("FAIL digit_%0d: pulses=%0d lat=%0d digit=%h inv=%b blank=%b, need 1 %0d %h 0 0",
                 d, p, l, sif.digit, sif.invalid, sif.blank, LAT, 4'(d));
      end
    end
    checks++;
    if (sif.change_cnt !== 16'd16) begin
      errors++; $display("FAIL digits_count: got %0d, need 16", sif.change_cnt);
    end
    checks++;
    if (sif2.change_cnt !== 2'd3 || sif2.digit !== 4'hF) begin
      errors++;
      $display("FAIL small_saturate: cnt=%0d digit=%h, need 3 and f", sif2.change_cnt, sif2.digit);
    end
  endtask

  task automatic test_glitch;
    int p, l, p1, p2;
    hold(~7'h5B, 40, p, l);
    checks++;
    if (p !== 1 || sif.digit !== 4'h5 || sif.change_cnt !== 16'd17) begin
      errors++;
      $display("FAIL glitch_setup: pulses=%0d digit=%h cnt=%0d, need 1 5 17", p, sif.digit, sif.change_cnt);
    end
    hold(~7'h7F, 10, p1, l);
    hold(~7'h5B, 40, p2, l);
    checks++;
    if (p1 + p2 !== 0 || sif.digit !== 4'h5 || sif.change_cnt !== 16'd17) begin
      errors++;
      $display("FAIL glitch_reject: pulses=%0d digit=%h cnt=%0d, need 0 5 17",
               p1 + p2, sif.digit, sif.change_cnt);
    end
  endtask

  task automatic test_blank_invalid;
    int p, l;
    hold(~7'h00, 40, p, l);
    checks++;
    if (p !== 1 || sif.blank !== 1'b1 || sif.invalid !== 1'b0 || sif.digit !== 4'h5 || sif.change_cnt !== 16'd18) begin
      errors++;
      $display("FAIL blank: pulses=%0d blank=%b inv=%b digit=%h cnt=%0d, need 1 1 0 5 18",
               p, sif.blank, sif.invalid, sif.digit, sif.change_cnt);
    end
    hold(~7'h01, 40, p, l);
    checks++;
    if (p !== 1 || sif.blank !== 1'b0 || sif.invalid !== 1'b1 || sif.digit !== 4'h5 || sif.change_cnt !== 16'd19) begin
      errors++;
      $display("FAIL illegal: pulses=%0d blank=%b inv=%b digit=%h cnt=%0d, need 1 0 1 5 19",
               p, sif.blank, sif.invalid, sif.digit, sif.change_cnt);
    end
  endtask

  task automatic test_reset_mid_settle;
    int p, l;
    hold(~lit_code(1), 5, p, l);
    #1 rst = 1'b1;
    #1;
    checks++;
    if (p !== 0 || {sif.digit, sif.blank, sif.invalid, sif.digit_valid, sif.change_cnt, sif.seq_err} !== 25'd0) begin
      errors++;
      $display("FAIL midsettle_reset: pulses=%0d digit=%h blank=%b inv=%b cnt=%0d, need 0 and all 0",
               p, sif.digit, sif.blank, sif.invalid, sif.change_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    hold(~lit_code(1), 40, p, l);
    checks++;
    if (p !== 1 || l !== LAT || sif.digit !== 4'h1 || sif.change_cnt !== 16'd1) begin
      errors++;
      $display("FAIL midsettle_requal: pulses=%0d lat=%0d digit=%h cnt=%0d, need 1 %0d 1 1",
               p, l, sif.digit, sif.change_cnt, LAT);
    end
  endtask

`ifdef SEVENSEG_SEQ_CHECK_EN
  task automatic test_seq;
    int p, l;
    do_reset(~lit_code(8));
    hold(~lit_code(8), 40, p, l);
    hold(~lit_code(9), 40, p, l);
    hold(~lit_code(0), 40, p, l);
    hold(~lit_code(1), 40, p, l);
    checks++;
    if (sif.seq_err !== 1'b0 || sif.digit !== 4'h1) begin
      errors++; $display("FAIL seq_ok: seq_err=%b digit=%h, need 0 1", sif.seq_err, sif.digit);
    end
    hold(~lit_code(3), 40, p, l);
    checks++;
    if (sif.seq_err !== 1'b1) begin
      errors++; $display("FAIL seq_skip: seq_err=%b, need 1", sif.seq_err);
    end
    hold(~lit_code(4), 40, p, l);
    checks++;
    if (sif.seq_err !== 1'b1) begin
      errors++; $display("FAIL seq_sticky: seq_err=%b, need 1", sif.seq_err);
    end
  endtask
`else
  task automatic test_seq;
    checks++;
    if (sif.seq_err !== 1'b0 || sif2.seq_err !== 1'b0) begin
      errors++; $display("FAIL seq_tied: seq_err=%b/%b, need 0", sif.seq_err, sif2.seq_err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_digits();
    test_glitch();
    test_blank_invalid();
    test_reset_mid_settle();
    test_seq();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
